// File: rtl/vga_text_banner.sv
// rtl/vga_text_banner.sv - text banner overlay: coordinate -> registered text pixel flag
// Two-stage pipeline: buffer lookup, then glyph ROM bit with blink gating.
module vga_text_banner #(
  parameter int NUM_CHARS    = 18,
  parameter int X0           = 180,
  parameter int Y0           = 464,
  parameter int BLOCK_LOG2   = 2,
  parameter int SCROLL_STEP  = 1,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] VGA_HORZ_COORD,
  input  logic [11:0] VGA_VERT_COORD,
  input  logic        frame_tick,
  input  logic [1:0]  mode,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [4:0]  wr_char,
  output logic        pixel_on,
  output logic        in_box
);

  localparam int W  = NUM_CHARS * 8 * (1 << BLOCK_LOG2);
  localparam int H  = 7 * (1 << BLOCK_LOG2);
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [12:0]   LP_X0    = 13'(X0);
  localparam logic [12:0]   LP_X1    = 13'(X0 + W);
  localparam logic [12:0]   LP_Y0    = 13'(Y0);
  localparam logic [12:0]   LP_Y1    = 13'(Y0 + H);
  localparam logic [12:0]   LP_W     = 13'(W);
  localparam logic [12:0]   LP_STEP  = 13'(SCROLL_STEP);
  localparam logic [12:0]   LP_NCH   = 13'(NUM_CHARS);
  localparam logic [5:0]    LP_NCH6  = 6'(NUM_CHARS);
  localparam logic [CW-1:0] LP_BLAST = CW'(BLINK_FRAMES - 1);

  // Glyph rows top to bottom, MSB of each 6-bit row is column 0.
  function automatic logic [41:0] glyph(input logic [4:0] code);
    case (code)
      5'd1:  glyph = 42'b011110_100001_100001_111111_100001_100001_100001;
      5'd2:  glyph = 42'b111110_100001_100001_111110_100001_100001_111110;
      5'd3:  glyph = 42'b011111_100000_100000_100000_100000_100000_011111;
      5'd4:  glyph = 42'b111110_100001_100001_100001_100001_100001_111110;
      5'd5:  glyph = 42'b111111_100000_100000_111110_100000_100000_111111;
      5'd6:  glyph = 42'b111111_100000_100000_111110_100000_100000_100000;
      5'd7:  glyph = 42'b011111_100000_100000_100111_100001_100001_011111;
      5'd8:  glyph = 42'b100001_100001_100001_111111_100001_100001_100001;
      5'd9:  glyph = 42'b111111_001100_001100_001100_001100_001100_111111;
      5'd10: glyph = 42'b000001_000001_000001_000001_000001_100001_011110;
      5'd11: glyph = 42'b100001_100010_100100_111000_100100_100010_100001;
      5'd12: glyph = 42'b100000_100000_100000_100000_100000_100000_111111;
      5'd13: glyph = 42'b100001_110011_101101_100001_100001_100001_100001;
      5'd14: glyph = 42'b100001_110001_101001_100101_100011_100001_100001;
      5'd15: glyph = 42'b011110_100001_100001_100001_100001_100001_011110;
      5'd16: glyph = 42'b111110_100001_100001_111110_100000_100000_100000;
      5'd17: glyph = 42'b011110_100001_100001_100001_100101_100010_011101;
      5'd18: glyph = 42'b111110_100001_100001_111110_100100_100010_100001;
      5'd19: glyph = 42'b011111_100000_100000_011110_000001_000001_111110;
      5'd20: glyph = 42'b111111_001100_001100_001100_001100_001100_001100;
      5'd21: glyph = 42'b100001_100001_100001_100001_100001_100001_011110;
      5'd22: glyph = 42'b100001_100001_100001_100001_100001_010010_001100;
      5'd23: glyph = 42'b100001_100001_100001_100001_101101_110011_100001;
      5'd24: glyph = 42'b100001_010010_001100_001100_001100_010010_100001;
      5'd25: glyph = 42'b100001_010010_001100_001100_001100_001100_001100;
      5'd26: glyph = 42'b111111_000010_000100_001000_010000_100000_111111;
      5'd27: glyph = 42'b000000_000000_111111_000000_111111_000000_000000;
      default: glyph = 42'd0;
    endcase
  endfunction

  logic [4:0]    r_buf [32];
  logic [12:0]   r_scroll;
  logic [CW-1:0] r_blink_cnt;
  logic          r_blink_vis;
  logic          r_box1;
  logic [4:0]    r_code1;
  logic [2:0]    r_col1;
  logic [2:0]    r_row1;
  logic          r_pixel_on;
  logic          r_in_box;

  logic [12:0] w_x, w_y, w_xrel, w_yrel, w_xsum, w_xe, w_idx, w_rowf;
  logic [12:0] w_ssum, w_snext;
  logic        w_box, w_idx_ok;
  logic [4:0]  w_code;
  logic [2:0]  w_col;
  logic [5:0]  w_shamt;
  logic [41:0] w_gsh;
  logic [5:0]  w_rsh;
  logic        w_bit;
  logic        w_unused;

  // Both bounds are checked on the unsigned coordinate before any subtraction.
  assign w_x      = {1'b0, VGA_HORZ_COORD};
  assign w_y      = {1'b0, VGA_VERT_COORD};
  assign w_box    = (w_x >= LP_X0) && (w_x < LP_X1) && (w_y >= LP_Y0) && (w_y < LP_Y1);
  assign w_xrel   = w_x - LP_X0;
  assign w_yrel   = w_y - LP_Y0;
  assign w_xsum   = w_xrel + r_scroll;
  assign w_xe     = (w_xsum >= LP_W) ? (w_xsum - LP_W) : w_xsum;
  assign w_idx    = w_xe >> (BLOCK_LOG2 + 3);
  assign w_idx_ok = (w_idx < LP_NCH);
  assign w_code   = w_idx_ok ? r_buf[w_idx[4:0]] : 5'd0;
  assign w_col    = w_xe[BLOCK_LOG2+2:BLOCK_LOG2];
  assign w_rowf   = w_yrel >> BLOCK_LOG2;

  assign w_ssum  = r_scroll + LP_STEP;
  assign w_snext = (w_ssum >= LP_W) ? (w_ssum - LP_W) : w_ssum;

  // Row select by shifting 6*row, then column select by shifting col.
  assign w_shamt = {r_row1, 2'b00} + {1'b0, r_row1, 1'b0};
  assign w_gsh   = glyph(r_code1) << w_shamt;
  assign w_rsh   = w_gsh[41:36] << r_col1;
  assign w_bit   = w_rsh[5] && (r_col1 < 3'd6);

  assign w_unused = ^{w_xe, w_idx, w_rowf, w_gsh[35:0], w_rsh[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= 5'd0;
    end else if (wr_en && ({1'b0, wr_addr} < LP_NCH6)) begin
      r_buf[wr_addr] <= wr_char;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scroll    <= 13'd0;
      r_blink_cnt <= '0;
      r_blink_vis <= 1'b1;
    end else begin
      if (mode == 2'd2) begin
        if (frame_tick) r_scroll <= w_snext;
      end else begin
        r_scroll <= 13'd0;
      end
      if (mode == 2'd1) begin
        if (frame_tick) begin
          if (r_blink_cnt == LP_BLAST) begin
            r_blink_cnt <= '0;
            r_blink_vis <= ~r_blink_vis;
          end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
          end
        end
      end else begin
        r_blink_cnt <= '0;
        r_blink_vis <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_box1     <= 1'b0;
      r_code1    <= 5'd0;
      r_col1     <= 3'd0;
      r_row1     <= 3'd0;
      r_pixel_on <= 1'b0;
      r_in_box   <= 1'b0;
    end else begin
      r_box1     <= w_box;
      r_code1    <= w_code;
      r_col1     <= w_col;
      r_row1     <= w_rowf[2:0];
      r_pixel_on <= r_box1 && w_bit && r_blink_vis;
      r_in_box   <= r_box1;
    end
  end

  assign pixel_on = r_pixel_on;
  assign in_box   = r_in_box;

endmodule

// File: doc/vga_text_banner.md
Name: vga_text_banner

Overview:
- Parametrised VGA text-overlay renderer: turns the current pixel coordinate into a 1-bit "text pixel on" flag for a banner of NUM_CHARS characters.
- Each character is a glyph from an internal 6x7 block-font ROM.
- Banner text is written at run time through a write port.
- Modes: static, blinking, or horizontally scrolling (wrap-around), stepped once per frame.
- Sits beside the other overlay generators, feeding the pixel colour mux.

Parameters:
- NUM_CHARS, 18, characters in banner buffer (1..32)
- X0, 180, left pixel column of banner box
- Y0, 464, top pixel row of banner box
- BLOCK_LOG2, 2, glyph cell is 2^BLOCK_LOG2 pixels square; character pitch = 8 cells
- SCROLL_STEP, 1, pixels advanced per frame_tick in scroll mode (< banner width)
- BLINK_FRAMES, 32, frame_ticks per blink half-period (>=1)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- VGA_HORZ_COORD  in  12  current pixel column
- VGA_VERT_COORD  in  12  current pixel row
- frame_tick  in  1  one-cycle pulse, once per frame
- mode  in  2  0 static, 1 blink, 2 scroll, 3 treated as static
- wr_en  in  1  write strobe for character buffer
- wr_addr  in  5  character slot
- wr_char  in  5  character code: 0 space, 1-26 A-Z, 27 '=', 28-31 blank
- pixel_on  out  1  text pixel lit, registered
- in_box  out  1  coordinate inside banner box, registered

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: pixel_on=0, in_box=0, all buffer slots=0 (space), scroll_off=0, blink counter=0, blink_vis=1, pipeline registers=0.
- Geometry:
  - W = NUM_CHARS*8*2^BLOCK_LOG2; H = 7*2^BLOCK_LOG2.
  - Box is X0 <= x < X0+W, Y0 <= y < Y0+H.
  - x_rel = x-X0, y_rel = y-Y0; all in 12-bit, compared before subtraction, so no underflow.
- Scroll mapping:
  - xe = x_rel + scroll_off; if xe >= W then xe -= W. A single subtraction suffices, since both terms are < W.
  - char index = xe >> (BLOCK_LOG2+3); col = xe[BLOCK_LOG2+2:BLOCK_LOG2]; row = y_rel >> BLOCK_LOG2.
  - col 6 and col 7 are inter-character gap and are always off.
- Pipeline, latency exactly 2 clk from coordinate to outputs:
  - Stage 1 registers box flag, char code read from buffer, col, and row.
  - Stage 2 registers the ROM bit: pixel_on = box & col<6 & glyph[code][row][col] & blink_vis; in_box = box.
- Font:
  - Glyph bitmaps are the team 6x7 block font.
  - 'L' (12): column 0 all rows, plus row 6 cols 0-5.
  - '=' (27): rows 2 and 4, cols 0-5.
  - Codes 0 and 28-31 are all-off.
- Write port:
  - On wr_en, slot wr_addr <= wr_char.
  - wr_addr >= NUM_CHARS is ignored.
  - A write and a stage-1 read of the same slot in the same cycle return the old value; the new value is used from the next cycle.
- Scroll (mode=2):
  - On each frame_tick, scroll_off <= scroll_off+SCROLL_STEP, minus W if the result is >= W.
  - In any other mode, scroll_off is held at 0 (cleared on the next clk).
- Blink (mode=1):
  - Counter increments on frame_tick.
  - On reaching BLINK_FRAMES-1 with a tick, the counter goes to 0 and blink_vis toggles.
  - In other modes, counter=0 and blink_vis=1.
- Simultaneous events: a mode change and frame_tick in the same cycle are evaluated with the new mode; the tick counts for that mode.
- Reset mid-frame: all state returns to reset values immediately; the buffer contents are lost.

Test Plan:
- Reset, then scan the full 800x600 field in static mode with an empty buffer -> pixel_on=0 everywhere; in_box=1 exactly for x 180..755, y 464..491.
- Write code 12 to slot 0, mode=0:
  - (180,464) -> pixel_on=1 two clocks later
  - (184,464) -> 0
  - (184,488) -> 1
  - (204,488) -> 0 (gap col 6)
  - (179,464) -> 0, in_box=0
  - (180,492) -> 0, in_box=0
- Write to slot 18 with code 12 -> buffer unchanged; pixel at (756,464) stays 0; slot 17 is unaffected.
- Mode=2, slot 0 = 'L', 4 frame_ticks:
  - (180,464) -> 0
  - (752,464) -> 1 (wrapped column 0)
  - after 576 total ticks, scroll_off is back to 0 and (180,464) -> 1
- Mode=1, slot 0 = 'L':
  - after 32 ticks, (180,464) -> 0 while in_box=1
  - after 64 ticks -> 1
  - switching to mode 0 mid-phase -> 1 on the next frame
- Assert rst_n low mid-scroll (scroll_off=100) -> outputs drop to 0 asynchronously; after release, buffer is empty and scroll_off=0.
